// File: rtl/slave_port_pkg.sv
// -----------------------------------------------------------------------------
// slave_port_pkg
// Shared bus package for the serial slave port.
//   SLAVE_DEVICE_ADDR_WIDTH : width of the device-select field of a bus address.
//   state_t                 : slave port state encoding.
//   cnt_width()             : bit-counter width for given address/data widths.
// -----------------------------------------------------------------------------
package slave_port_pkg;

  localparam int SLAVE_DEVICE_ADDR_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    RDATA = 3'd5
  } state_t;

  // $clog2 of the larger width, never narrower than one bit.
  function automatic int cnt_width(input int addr_w, input int data_w);
    int m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/slave_port_bit_deserializer.sv
// -----------------------------------------------------------------------------
// bit_deserializer
// LSB-first serial-to-parallel capture with its own bit counter.
//   clk      : clock
//   rstn     : asynchronous active-low reset
//   shift_en : capture din into bit [counter] this cycle
//   din      : serial input bit
//   data_o   : captured word; holds while shift_en is low
//   done_o   : high in the cycle the last bit (WIDTH-1) is captured
// -----------------------------------------------------------------------------
module bit_deserializer
  import slave_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] data_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = shift_en && (cnt_q == LAST);
  assign data_o = data_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (shift_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (cnt_q == CNT_W'(i)) data_d[i] = din;
      end
      // Counter returns to zero on the terminal bit, ready for the next word.
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port
// Serial bus slave: receives address (and write data) bit-serially, issues a
// write or read strobe to the device, and returns read data bit-serially.
//   clk, rstn      : clock, asynchronous active-low reset
//   swdata, smode  : serial address/write-data bit, mode (0 read, 1 write)
//   mvalid         : swdata qualifier (already decoded for this slave)
//   srdata, svalid : serial read-data bit and its qualifier (registered)
//   daddr, dwdata  : device address / write data
//   dwen, dren     : device write / read strobes
//   drdata         : device read data
//   dready         : device handshake, only with SLAVE_PORT_DREADY_EN defined;
//                    otherwise WRITE and READ last exactly one cycle.
// -----------------------------------------------------------------------------
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dwen,
  output logic                  dren,
  input  logic [DATA_WIDTH-1:0] drdata
`ifdef SLAVE_PORT_DREADY_EN
  ,
  input  logic                  dready
`endif
);

  localparam int               CNT_W    = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;

  logic addr_shift, addr_done;
  logic data_shift, data_done;
  logic dev_ack;

`ifdef SLAVE_PORT_DREADY_EN
  assign dev_ack = dready;
`else
  assign dev_ack = 1'b1;
`endif

  // The first address bit is taken in IDLE, so the address deserializer
  // shifts in both IDLE and ADDR; its counter is zero whenever IDLE is entered.
  assign addr_shift = mvalid && ((state_q == IDLE) || (state_q == ADDR));
  assign data_shift = mvalid && (state_q == WDATA);

  bit_deserializer #(.WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_addr_des (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (addr_shift),
    .din      (swdata),
    .data_o   (daddr),
    .done_o   (addr_done)
  );

  bit_deserializer #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_data_des (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (data_shift),
    .din      (swdata),
    .data_o   (dwdata),
    .done_o   (data_done)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rdata_d = rdata_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (mvalid) begin
          mode_d  = smode;
          state_d = addr_done ? (smode ? WDATA : READ) : ADDR;
        end
      end
      ADDR:  if (addr_done) state_d = mode_q ? WDATA : READ;
      WDATA: if (data_done) state_d = WRITE;
      WRITE: if (dev_ack) state_d = IDLE;
      READ: begin
        if (dev_ack) begin
          rdata_d = drdata;
          rcnt_d  = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (rcnt_q == LAST_BIT) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Serial outputs are registered: compute them from the next state so
    // svalid is high exactly for the cycles the port sits in RDATA.
    svalid_d = (state_d == RDATA);
    srdata_d = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (svalid_d && (rcnt_d == CNT_W'(i))) srdata_d = rdata_d[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      rdata_q  <= '0;
      rcnt_q   <= '0;
      srdata_q <= 1'b0;
      svalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rcnt_q   <= rcnt_d;
      srdata_q <= srdata_d;
      svalid_q <= svalid_d;
    end
  end

  assign srdata = srdata_q;
  assign svalid = svalid_q;
  assign dwen   = (state_q == WRITE);
  assign dren   = (state_q == READ);

endmodule

// File: tb/tb_slave_port.sv
// -----------------------------------------------------------------------------
// tb_slave_port
// Scoreboard bench for slave_port (ADDR_WIDTH=12, DATA_WIDTH=8). Stimulus pushes
// expected device strobes and serial read bits; a negedge monitor pops and
// compares whenever dwen, dren or svalid is high.
// -----------------------------------------------------------------------------
module tb_slave_port;

  logic        clk = 1'b0;
  logic        rstn;
  logic        swdata, smode, mvalid;
  logic        srdata, svalid;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic        dwen, dren;
  logic [7:0]  drdata;
`ifdef SLAVE_PORT_DREADY_EN
  logic        dready;
`endif

  always #5 clk = ~clk;

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .swdata (swdata),
    .smode  (smode),
    .mvalid (mvalid),
    .srdata (srdata),
    .svalid (svalid),
    .daddr  (daddr),
    .dwdata (dwdata),
    .dwen   (dwen),
    .dren   (dren),
    .drdata (drdata)
`ifdef SLAVE_PORT_DREADY_EN
    ,
    .dready (dready)
`endif
  );

  typedef enum int {EV_WR = 0, EV_RD = 1, EV_BIT = 2} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [11:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_write(input logic [11:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = EV_WR; e.addr = a; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic push_read(input logic [11:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = EV_RD; e.addr = a; e.data = 8'h00;
    sb_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.kind = EV_BIT; e.addr = 12'h000; e.data = {7'b0, d[i]};
      sb_q.push_back(e);
    end
  endtask

  task automatic observe(input ev_kind_t k);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
      return;
    end
    e = sb_q.pop_front();
    check("event_kind", k, e.kind);
    if (e.kind != k) return;
    case (k)
      EV_WR: begin
        $display("write  daddr=%03h dwdata=%02h", daddr, dwdata);
        check("wr_addr", daddr, e.addr);
        check("wr_data", dwdata, e.data);
      end
      EV_RD: begin
        $display("read   daddr=%03h", daddr);
        check("rd_addr", daddr, e.addr);
      end
      default: begin
        $display("rbit   srdata=%0b", srdata);
        check("rd_bit", srdata, e.data[0]);
      end
    endcase
  endtask

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (dwen)   observe(EV_WR);
      if (dren)   observe(EV_RD);
      if (svalid) observe(EV_BIT);
    end
  end

  // Serial driver. Between valid bits during gaps swdata is toggled to junk;
  // smode is inverted after the first bit since only the first is sampled.
  task automatic send_xfer(input logic mode, input logic [11:0] addr, input logic [7:0] data,
                           input int gap, input bit start_now, input bit hold);
    for (int i = 0; i < 12; i++) begin
      if (!(start_now && i == 0)) @(negedge clk);
      mvalid = 1'b1; swdata = addr[i]; smode = (i == 0) ? mode : ~mode;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk); mvalid = 1'b0; swdata = ~addr[i];
      end
    end
    if (mode) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        mvalid = 1'b1; swdata = data[i];
        for (int g = 0; g < gap; g++) begin
          @(negedge clk); mvalid = 1'b0; swdata = ~data[i];
        end
      end
    end
    @(negedge clk);
    if (hold) swdata = 1'b1;   // mvalid stays high: must be ignored
    else      mvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 80 && sb_q.size() != 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(name, sb_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_daddr"},  daddr,  0);
    check({tag, "_dwdata"}, dwdata, 0);
    check({tag, "_srdata"}, srdata, 0);
    check({tag, "_svalid"}, svalid, 0);
    check({tag, "_dwen"},   dwen,   0);
    check({tag, "_dren"},   dren,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int c;
    rstn = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0; drdata = 8'h00;
`ifdef SLAVE_PORT_DREADY_EN
    dready = 1'b1;
`endif
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Plain write
    push_write(12'h123, 8'hA5);
    send_xfer(1'b1, 12'h123, 8'hA5, 0, 1'b0, 1'b0);
    drain("drain_write");
    check("idle_hold_daddr", daddr, 12'h123);
    check("idle_hold_dwdata", dwdata, 8'hA5);

    // Plain read
    drdata = 8'h3C;
    push_read(12'h045, 8'h3C);
    send_xfer(1'b0, 12'h045, 8'h00, 0, 1'b0, 1'b0);
    drain("drain_read");

    // Write with 3-cycle gaps between every bit
    push_write(12'hFFF, 8'h81);
    send_xfer(1'b1, 12'hFFF, 8'h81, 3, 1'b0, 1'b0);
    drain("drain_gap_write");

    // Reset after 5 address bits of a write
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mvalid = 1'b1; swdata = i[0]; smode = 1'b1;
    end
    @(negedge clk); mvalid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk); rstn = 1'b1;
    push_write(12'h00A, 8'h5A);
    send_xfer(1'b1, 12'h00A, 8'h5A, 0, 1'b0, 1'b0);
    drain("drain_after_reset");

    // Back-to-back: read (mvalid held high through READ/RDATA), then write
    drdata = 8'h96;
    push_read(12'h7E1, 8'h96);
    push_write(12'h2B4, 8'hC3);
    send_xfer(1'b0, 12'h7E1, 8'h00, 0, 1'b0, 1'b1);
    seen = 1'b0;
    for (c = 0; c < 40; c++) begin
      if (svalid) seen = 1'b1;
      else if (seen) break;
      @(negedge clk);
    end
    check("b2b_rdata_end_seen", {31'b0, seen && (c < 40)}, 1);
    send_xfer(1'b1, 12'h2B4, 8'hC3, 0, 1'b1, 1'b0);
    drain("drain_b2b");

`ifdef SLAVE_PORT_DREADY_EN
    // dready low for three WRITE cycles -> dwen high four cycles
    dready = 1'b0;
    for (int i = 0; i < 4; i++) push_write(12'h3C0, 8'h69);
    send_xfer(1'b1, 12'h3C0, 8'h69, 0, 1'b0, 1'b0);
    for (c = 0; c < 20 && !dwen; c++) @(negedge clk);
    check("dready_dwen_seen", {31'b0, dwen}, 1);
    repeat (3) @(negedge clk);
    dready = 1'b1;
    drain("drain_dready");
`endif

    check("final_dwen", dwen, 0);
    check("final_svalid", svalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
